pwm_generator: RTL and testbench
================================

// Module: pwm_generator
// PURPOSE
//  Per-transducer PWM output stage; consumes the LEFT/RIGHT/OVER edge values and CYCLE produced upstream.
//  Runs a local period counter 0..CYCLE-1, double-buffers edge settings, and applies them only at a
//  period boundary so PWM_OUT never glitches mid-period. One instance per transducer; SYNC aligns all.
// PARAMETERS
//  WIDTH  13  bit width of CYCLE, LEFT, RIGHT and the period counter
// PORTS
//  CLK           in   1      system clock; all logic on posedge
//  RST_N         in   1      asynchronous, active-low reset
//  SYNC          in   1      pulse: restart period counter at 0, apply pending settings immediately
//  UPDATE        in   1      pulse: capture CYCLE/LEFT/RIGHT/OVER into pending buffer
//  CYCLE         in   WIDTH  period length in clocks
//  LEFT          in   WIDTH  rising-edge position, in [0, CYCLE-1]
//  RIGHT         in   WIDTH  falling-edge position, in [0, CYCLE-1]
//  OVER          in   1      1: pulse wraps through counter 0 (LEFT > RIGHT, or full-on)
//  PWM_OUT       out  1      registered PWM output
//  PERIOD_START  out  1      1-clock pulse, registered alongside the counter = 0 sample
//  PENDING       out  1      1 while captured settings wait for a period boundary
// BEHAVIOUR
//  Reset (async, RST_N=0): cnt=0; active cycle/left/right/over=0; pending regs=0; PENDING=0; PWM_OUT=0;
//   PERIOD_START=0. Effects are immediate, including mid-period. First clock after release counts normally.
//  Counter: if active cycle < 2, cnt held at 0 and PWM_OUT forced 0 (disabled).
//   Otherwise cnt increments each clock; at cnt == cycle-1 next cnt=0 (wrap).
//  Capture: UPDATE=1 latches inputs into pending regs, sets PENDING. UPDATE while PENDING overwrites (last wins).
//  Apply: at wrap clock (cnt==cycle-1) or disabled state, if PENDING: active<=pending, PENDING<=0.
//   UPDATE on the wrap clock itself bypasses: inputs go straight to active, PENDING stays/clears to 0.
//  SYNC: next cnt=0; if PENDING or UPDATE same clock, apply as above; SYNC overrides wrap.
//  Compare (on cnt, using active regs), result registered into PWM_OUT -> 1-clock latency:
//   over=0: high iff left <= cnt < right  (left==right -> never high, duty 0)
//   over=1: high iff cnt >= left or cnt < right (left==right -> always high, full duty)
//   High time per period = (right-left) mod cycle, or cycle when over=1 and left==right.
//  PERIOD_START: registered from (cnt==0 and enabled), aligned with PWM_OUT for that count.
//  Unsigned arithmetic only; LEFT/RIGHT >= CYCLE are out of contract (compare still defined, no checks).
//  New settings take effect on the first PWM_OUT sample of the following period; no partial periods.
// TESTING
//  1 Reset: RST_N=0 mid-pulse -> PWM_OUT, PERIOD_START, PENDING =0 same instant; cnt restarts at 0.
//  2 CYCLE=10,LEFT=2,RIGHT=7,OVER=0, UPDATE+SYNC -> per period PWM_OUT high for cnt 2..6 (5 clocks),
//    observed one clock later; PERIOD_START every 10 clocks.
//  3 CYCLE=10,LEFT=8,RIGHT=3,OVER=1 -> high for cnt 8,9,0,1,2 (5 clocks, wrap-through); LEFT=RIGHT=4,
//    OVER=1 -> constantly high; LEFT=RIGHT=4,OVER=0 -> constantly low.
//  4 Running 2..7; UPDATE LEFT=0,RIGHT=9 at cnt=4 -> PENDING=1, current period unchanged,
//    new pattern from next cnt=0, PENDING=0 after wrap; second UPDATE before wrap -> last one applied.
//  5 UPDATE on wrap clock (cnt=9) -> new settings used from cnt=0 directly, PENDING never asserts.
//  6 CYCLE=1 or 0 applied -> PWM_OUT=0, cnt=0, PERIOD_START=0; later UPDATE CYCLE=10 applies immediately.

Source files
------------

// File: rtl/pwm_generator.sv
// Per-transducer PWM output stage with double-buffered edge settings.
// Settings move from pending to active only at a period boundary.
module pwm_generator #(
   parameter int WIDTH = 13
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             SYNC,
   input  logic             UPDATE,
   input  logic [WIDTH-1:0] CYCLE,
   input  logic [WIDTH-1:0] LEFT,
   input  logic [WIDTH-1:0] RIGHT,
   input  logic             OVER,
   output logic             PWM_OUT,
   output logic             PERIOD_START,
   output logic             PENDING
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_cyc;
   logic [WIDTH-1:0] r_left;
   logic [WIDTH-1:0] r_right;
   logic             r_over;
   logic [WIDTH-1:0] r_p_cyc;
   logic [WIDTH-1:0] r_p_left;
   logic [WIDTH-1:0] r_p_right;
   logic             r_p_over;
   logic             r_pending;
   logic             r_pwm;
   logic             r_ps;

   logic w_en;
   logic w_last;
   logic w_bound;
   logic w_ge_left;
   logic w_lt_right;
   logic w_hi;

   assign w_en       = (r_cyc >= WIDTH'(2));
   assign w_last     = w_en && (r_cnt == (r_cyc - WIDTH'(1)));
   assign w_bound    = SYNC || !w_en || w_last;
   assign w_ge_left  = (r_cnt >= r_left);
   assign w_lt_right = (r_cnt < r_right);
   assign w_hi       = r_over ? (w_ge_left || w_lt_right)
                              : (w_ge_left && w_lt_right);

   // Period counter: restarts on sync, wrap, or while disabled.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cnt <= '0;
      end else if (w_bound) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   // Settings: boundary loads active (update bypasses pending), else buffer.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_cyc     <= '0;
         r_left    <= '0;
         r_right   <= '0;
         r_over    <= 1'b0;
         r_p_cyc   <= '0;
         r_p_left  <= '0;
         r_p_right <= '0;
         r_p_over  <= 1'b0;
         r_pending <= 1'b0;
      end else if (w_bound) begin
         if (UPDATE) begin
            r_cyc   <= CYCLE;
            r_left  <= LEFT;
            r_right <= RIGHT;
            r_over  <= OVER;
         end else if (r_pending) begin
            r_cyc   <= r_p_cyc;
            r_left  <= r_p_left;
            r_right <= r_p_right;
            r_over  <= r_p_over;
         end
         r_pending <= 1'b0;
      end else if (UPDATE) begin
         r_p_cyc   <= CYCLE;
         r_p_left  <= LEFT;
         r_p_right <= RIGHT;
         r_p_over  <= OVER;
         r_pending <= 1'b1;
      end
   end

   // Registered compare and period marker, one clock behind the counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pwm <= 1'b0;
         r_ps  <= 1'b0;
      end else begin
         r_pwm <= w_en && w_hi;
         r_ps  <= w_en && (r_cnt == '0);
      end
   end

   assign PWM_OUT      = r_pwm;
   assign PERIOD_START = r_ps;
   assign PENDING      = r_pending;

endmodule

// File: tb/tb_pwm_generator.sv
// Self-checking bench for pwm_generator: vector table, directed
// corner sequences and randomized traffic against a period model.
module tb_pwm_generator;

   localparam int W = 13;

   logic         CLK;
   logic         RST_N;
   logic         SYNC;
   logic         UPDATE;
   logic [W-1:0] CYCLE;
   logic [W-1:0] LEFT;
   logic [W-1:0] RIGHT;
   logic         OVER;
   logic         PWM_OUT;
   logic         PERIOD_START;
   logic         PENDING;

   int n_vec;
   int n_bad;

   // reference model: period position plus active/pending settings
   int m_cnt, m_cyc, m_l, m_r;
   bit m_o;
   bit m_pend;
   int p_cyc, p_l, p_r;
   bit p_o;
   bit e_pwm, e_ps, e_pend;

   typedef struct {
      bit s;
      bit u;
      int c;
      int l;
      int r;
      bit o;
      bit pwm;
      bit ps;
      bit pend;
   } vec_t;

   vec_t tbl[19];

   pwm_generator #(.WIDTH(W)) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .SYNC(SYNC),
      .UPDATE(UPDATE),
      .CYCLE(CYCLE),
      .LEFT(LEFT),
      .RIGHT(RIGHT),
      .OVER(OVER),
      .PWM_OUT(PWM_OUT),
      .PERIOD_START(PERIOD_START),
      .PENDING(PENDING)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // high when the position measured from the rising edge, modulo
   // the period, lies inside the pulse length
   function automatic bit model_high(int cnt, int cyc, int l, int r, bit o);
      int ht;
      int pos;
      ht = ((r - l) % cyc + cyc) % cyc;
      if (o && l == r) ht = cyc;
      pos = ((cnt - l) % cyc + cyc) % cyc;
      return pos < ht;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_cyc = 0; m_l = 0; m_r = 0; m_o = 0;
      m_pend = 0; p_cyc = 0; p_l = 0; p_r = 0; p_o = 0;
      e_pwm = 0; e_ps = 0; e_pend = 0;
   endtask

   task automatic model_step(input bit s, input bit u,
                             input int c, input int l,
                             input int r, input bit o);
      bit en;
      bit bnd;
      en = (m_cyc >= 2);
      e_pwm = en && model_high(m_cnt, m_cyc, m_l, m_r, m_o);
      e_ps = en && (m_cnt == 0);
      bnd = s || !en || (m_cnt == m_cyc - 1);
      if (bnd) begin
         if (u) begin
            m_cyc = c; m_l = l; m_r = r; m_o = o;
         end else if (m_pend) begin
            m_cyc = p_cyc; m_l = p_l; m_r = p_r; m_o = p_o;
         end
         m_pend = 0;
         m_cnt = 0;
      end else begin
         if (u) begin
            p_cyc = c; p_l = l; p_r = r; p_o = o; m_pend = 1;
         end
         m_cnt = m_cnt + 1;
      end
      e_pend = m_pend;
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mchk(input string tag);
      chk({tag, ".pwm"}, PWM_OUT, e_pwm);
      chk({tag, ".ps"}, PERIOD_START, e_ps);
      chk({tag, ".pend"}, PENDING, e_pend);
   endtask

   // drive on negedge, let the edge happen, sample 1ns later
   task automatic tick(input bit s, input bit u, input int c,
                       input int l, input int r, input bit o);
      @(negedge CLK);
      SYNC = s; UPDATE = u;
      CYCLE = W'(c); LEFT = W'(l); RIGHT = W'(r); OVER = o;
      @(posedge CLK);
      model_step(s, u, c, l, r, o);
      #1;
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0, 0);
   endtask

   task automatic rand_cfg(output int c, output int l,
                           output int r, output bit o);
      if ($urandom_range(0, 15) == 0) begin
         c = $urandom_range(0, 1); l = 0; r = 0; o = 0;
      end else begin
         c = $urandom_range(2, 16);
         l = $urandom_range(0, c - 1);
         r = $urandom_range(0, c - 1);
         if (l > r) o = 1;
         else if (l == r) o = 1'($urandom_range(0, 1));
         else o = 0;
      end
   endtask

   initial begin
      int hi;
      int ps;
      int c, l, r;
      bit o;
      bit s, u;
      bit seen;

      n_vec = 0;
      n_bad = 0;
      RST_N = 0; SYNC = 0; UPDATE = 0;
      CYCLE = '0; LEFT = '0; RIGHT = '0; OVER = 0;
      model_reset();

      tbl[0]  = '{1, 1, 4, 1, 3, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      tbl[6]  = '{0, 1, 4, 0, 2, 0, 1, 0, 1};
      tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 1, 4, 3, 1, 1, 0, 0, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
      tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[16] = '{1, 1, 1, 0, 0, 0, 1, 0, 0};
      tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

      // reset state while clock runs
      repeat (3) @(posedge CLK);
      #1;
      chk("rst.pwm", PWM_OUT, 1'b0);
      chk("rst.ps", PERIOD_START, 1'b0);
      chk("rst.pend", PENDING, 1'b0);
      @(negedge CLK);
      RST_N = 1;

      // vector table from reset
      for (int i = 0; i < 19; i++) begin
         tick(tbl[i].s, tbl[i].u, tbl[i].c, tbl[i].l, tbl[i].r, tbl[i].o);
         chk($sformatf("tbl%0d.pwm", i), PWM_OUT, tbl[i].pwm);
         chk($sformatf("tbl%0d.ps", i), PERIOD_START, tbl[i].ps);
         chk($sformatf("tbl%0d.pend", i), PENDING, tbl[i].pend);
      end

      // disabled: new cycle applies on the next clock
      tick(0, 1, 10, 2, 7, 0);
      mchk("dis_upd");
      chk("dis_upd.pend0", PENDING, 1'b0);

      // basic 2..7 pattern: 5 high clocks and 1 start per period
      tick(1, 1, 10, 2, 7, 0);
      mchk("p27.apply");
      hi = 0; ps = 0;
      for (int i = 0; i < 20; i++) begin
         idle();
         mchk($sformatf("p27.c%0d", i));
         hi += int'(PWM_OUT);
         ps += int'(PERIOD_START);
      end
      chk_int("p27.high", hi, 10);
      chk_int("p27.starts", ps, 2);

      // wrap-through 8..2
      tick(1, 1, 10, 8, 3, 1);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         idle();
         mchk($sformatf("wrap.c%0d", i));
         hi += int'(PWM_OUT);
      end
      chk_int("wrap.high", hi, 5);

      // left == right with over: full on
      tick(1, 1, 10, 4, 4, 1);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         idle();
         hi += int'(PWM_OUT);
      end
      chk_int("full.high", hi, 10);

      // left == right without over: full off
      tick(1, 1, 10, 4, 4, 0);
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         idle();
         hi += int'(PWM_OUT);
      end
      chk_int("zero.high", hi, 0);

      // mid-period update, then overwrite before the wrap
      tick(1, 1, 10, 2, 7, 0);
      repeat (5) idle();
      tick(0, 1, 10, 0, 9, 0);
      chk("mid.pend", PENDING, 1'b1);
      mchk("mid.u1");
      tick(0, 1, 10, 1, 3, 0);
      mchk("mid.u2");
      for (int i = 0; i < 14; i++) begin
         idle();
         mchk($sformatf("mid.c%0d", i));
      end

      // async reset while the pulse is high
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         idle();
         seen = PWM_OUT;
      end
      chk("ar.seen_high", seen, 1'b1);
      #2;
      RST_N = 0;
      #1;
      model_reset();
      chk("ar.pwm", PWM_OUT, 1'b0);
      chk("ar.ps", PERIOD_START, 1'b0);
      chk("ar.pend", PENDING, 1'b0);
      @(negedge CLK);
      RST_N = 1;
      tick(0, 1, 10, 2, 7, 0);
      mchk("ar.restart");
      repeat (4) begin
         idle();
         mchk("ar.run");
      end

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rand_cfg(c, l, r, o);
         u = ($urandom_range(0, 5) == 0);
         s = ($urandom_range(0, 39) == 0);
         tick(s, u, c, l, r, o);
         mchk("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
